// File: rtl/module_spi_sequencer.sv
// module_spi_sequencer
//
// Host-side command sequencer for the SPI interface register port. One start
// request writes up to N transmit bytes into the SPI data register bank,
// writes the control word that launches the transfer, polls the control
// register until the hardware clears the send bit, reads the received bytes
// back and finally writes a zero control word to release chip select.
//
// Ports
//   clk_i      in   system clock
//   rst_ni     in   asynchronous active-low reset
//   start_i    in   one-cycle request, sampled only in IDLE
//   n_bytes_i  in   byte count (1..N), sampled with start_i
//   tx_data_i  in   transmit bytes, byte k at [8k+7:8k], sampled with start_i
//   salida_i   in   read data from the SPI interface
//   wr_o       out  register write enable to the SPI interface
//   reg_sel_o  out  0 = control register, 1 = data register
//   addr_o     out  data register address
//   data_o     out  write data to the SPI interface
//   rx_data_o  out  received bytes, same packing as tx_data_i
//   busy_o     out  transaction in progress
//   done_o     out  one-cycle completion pulse
//   error_o    out  bad byte count or poll timeout, valid with done_o
module module_spi_sequencer #(
    parameter int N       = 8,
    parameter int WR_HOLD = 10,
    parameter int RD_WAIT = 12,
    parameter int TIMEOUT = 65535
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [$clog2(N):0]   n_bytes_i,
    input  logic [8*N-1:0]       tx_data_i,
    input  logic [31:0]          salida_i,
    output logic                 wr_o,
    output logic                 reg_sel_o,
    output logic [$clog2(N)-1:0] addr_o,
    output logic [31:0]          data_o,
    output logic [8*N-1:0]       rx_data_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o
);

    localparam int AW = $clog2(N);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_DATA,
        S_WR_CTRL,
        S_POLL,
        S_RD_DATA,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   n_reg;
    logic [CW-1:0]   k_reg;
    logic [8*N-1:0]  tx_reg;
    logic [15:0]     cnt_reg;
    logic [16:0]     poll_cnt_reg;

    logic [CW-1:0]   k_next;
    logic            k_last;
    logic [8:0]      n_minus1;
    logic [31:0]     ctrl_word;
    logic            start_valid;
    logic            hold_end;
    logic            rd_sample;
    logic            capture_en;
    logic            unused_salida;

    assign k_next      = k_reg + CW'(1);
    assign k_last      = (k_next == n_reg);
    assign n_minus1    = 9'(n_reg) - 9'd1;
    assign ctrl_word   = {19'b0, n_minus1, 4'b0011};
    assign start_valid = (n_bytes_i != '0) && (n_bytes_i <= CW'(N));
    // Last high cycle of a WR_HOLD-long write strobe.
    assign hold_end    = (cnt_reg == 16'(WR_HOLD - 1));
    // Address/select have settled long enough for salida_i to be trusted.
    assign rd_sample   = (cnt_reg == 16'(RD_WAIT));
    assign capture_en  = (state_reg == S_RD_DATA) && rd_sample;

    assign unused_salida = ^salida_i[31:8];

    // Receive byte registers; each byte only updates when its own index is
    // being read, so bytes beyond the current count keep earlier values.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rx_byte
            logic [7:0] byte_reg;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    byte_reg <= 8'h00;
                end else if (capture_en && (k_reg == CW'(gi))) begin
                    byte_reg <= salida_i[7:0];
                end
            end
            assign rx_data_o[8*gi +: 8] = byte_reg;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= S_IDLE;
            n_reg        <= '0;
            k_reg        <= '0;
            tx_reg       <= '0;
            cnt_reg      <= '0;
            poll_cnt_reg <= '0;
            wr_o         <= 1'b0;
            reg_sel_o    <= 1'b0;
            addr_o       <= '0;
            data_o       <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start_i) begin
                        busy_o <= 1'b1;
                        if (start_valid) begin
                            n_reg     <= n_bytes_i;
                            tx_reg    <= tx_data_i;
                            error_o   <= 1'b0;
                            k_reg     <= '0;
                            cnt_reg   <= '0;
                            // First data write starts on the accept edge.
                            reg_sel_o <= 1'b1;
                            addr_o    <= '0;
                            data_o    <= {24'b0, tx_data_i[7:0]};
                            wr_o      <= 1'b1;
                            state_reg <= S_WR_DATA;
                        end else begin
                            error_o   <= 1'b1;
                            state_reg <= S_DONE;
                        end
                    end
                end

                S_WR_DATA: begin
                    if (wr_o) begin
                        if (hold_end) wr_o <= 1'b0;
                        else          cnt_reg <= cnt_reg + 16'd1;
                    end else begin
                        // Gap cycle: set up and launch the next write.
                        cnt_reg <= '0;
                        wr_o    <= 1'b1;
                        k_reg   <= k_next;
                        if (k_last) begin
                            reg_sel_o <= 1'b0;
                            data_o    <= ctrl_word;
                            state_reg <= S_WR_CTRL;
                        end else begin
                            addr_o <= k_next[AW-1:0];
                            data_o <= {24'b0, tx_reg[{k_next[AW-1:0], 3'b000} +: 8]};
                        end
                    end
                end

                S_WR_CTRL: begin
                    if (wr_o) begin
                        if (hold_end) wr_o <= 1'b0;
                        else          cnt_reg <= cnt_reg + 16'd1;
                    end else begin
                        cnt_reg      <= '0;
                        poll_cnt_reg <= '0;
                        state_reg    <= S_POLL;
                    end
                end

                S_POLL: begin
                    if (poll_cnt_reg != '1) poll_cnt_reg <= poll_cnt_reg + 17'd1;
                    if (!rd_sample) cnt_reg <= cnt_reg + 16'd1;
                    if (rd_sample && !salida_i[0]) begin
                        k_reg     <= '0;
                        cnt_reg   <= '0;
                        reg_sel_o <= 1'b1;
                        addr_o    <= '0;
                        state_reg <= S_RD_DATA;
                    end else if (poll_cnt_reg >= 17'(TIMEOUT - 1)) begin
                        // Send bit never cleared: give up and release CS.
                        error_o   <= 1'b1;
                        cnt_reg   <= '0;
                        reg_sel_o <= 1'b0;
                        data_o    <= '0;
                        wr_o      <= 1'b1;
                        state_reg <= S_RELEASE;
                    end
                end

                S_RD_DATA: begin
                    if (!rd_sample) begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end else begin
                        cnt_reg <= '0;
                        k_reg   <= k_next;
                        if (k_last) begin
                            reg_sel_o <= 1'b0;
                            data_o    <= '0;
                            wr_o      <= 1'b1;
                            state_reg <= S_RELEASE;
                        end else begin
                            addr_o <= k_next[AW-1:0];
                        end
                    end
                end

                S_RELEASE: begin
                    if (wr_o) begin
                        if (hold_end) wr_o <= 1'b0;
                        else          cnt_reg <= cnt_reg + 16'd1;
                    end else begin
                        state_reg <= S_DONE;
                    end
                end

                S_DONE: begin
                    done_o    <= 1'b1;
                    busy_o    <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_module_spi_sequencer.sv
// Testbench for module_spi_sequencer: directed transactions against a small
// SPI register model; expected writes and completions go into queues that a
// negedge monitor pops and compares.
module tb_module_spi_sequencer;

    localparam int N       = 8;
    localparam int WR_HOLD = 10;
    localparam int RD_WAIT = 12;
    localparam int TIMEOUT = 100;
    localparam int AW      = $clog2(N);

    logic            clk_i     = 1'b0;
    logic            rst_ni    = 1'b0;
    logic            start_i   = 1'b0;
    logic [AW:0]     n_bytes_i = '0;
    logic [8*N-1:0]  tx_data_i = '0;
    logic [31:0]     salida_i;
    logic            wr_o;
    logic            reg_sel_o;
    logic [AW-1:0]   addr_o;
    logic [31:0]     data_o;
    logic [8*N-1:0]  rx_data_o;
    logic            busy_o;
    logic            done_o;
    logic            error_o;

    always #5 clk_i = ~clk_i;

    module_spi_sequencer #(
        .N(N), .WR_HOLD(WR_HOLD), .RD_WAIT(RD_WAIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .n_bytes_i(n_bytes_i), .tx_data_i(tx_data_i), .salida_i(salida_i),
        .wr_o(wr_o), .reg_sel_o(reg_sel_o), .addr_o(addr_o), .data_o(data_o),
        .rx_data_o(rx_data_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          reg_sel;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct packed {
        logic           err;
        logic [8*N-1:0] rx;
    } done_t;

    wr_t   exp_wr_q[$];
    done_t exp_done_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // SPI register model: control write sets/clears send; send self-clears
    // 40 cycles after a control write unless stuck.
    logic [7:0] spi_rx [N];
    logic       send_bit   = 1'b0;
    bit         stuck      = 1'b0;
    int         send_timer = 0;
    logic       wr_seen    = 1'b0;

    assign salida_i = reg_sel_o ? {24'b0, spi_rx[addr_o]} : {31'b0, send_bit};

    always @(posedge clk_i) begin
        wr_seen <= wr_o;
        if (wr_o && !wr_seen && !reg_sel_o) begin
            send_bit   <= data_o[0];
            send_timer <= 40;
        end else if (send_bit && !stuck) begin
            if (send_timer <= 1) send_bit <= 1'b0;
            else                 send_timer <= send_timer - 1;
        end
    end

    // Monitor
    logic wr_d   = 1'b0;
    wr_t  cur_w;
    int   hi_len = 0;

    always @(negedge clk_i) begin
        wr_t   now_w;
        wr_t   ew;
        done_t ed;
        now_w = {reg_sel_o, addr_o, data_o};
        if (wr_o && !wr_d) begin
            hi_len <= 1;
            cur_w  <= now_w;
            if (exp_wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got 0x%0h expected none", now_w);
            end else begin
                ew = exp_wr_q.pop_front();
                check("write_sel_data", {31'b0, now_w.reg_sel, now_w.data}, {31'b0, ew.reg_sel, ew.data});
                if (ew.reg_sel) check("write_addr", 64'(now_w.addr), 64'(ew.addr));
                $display("write sel=%0d addr=%0d data=0x%08h", now_w.reg_sel, now_w.addr, now_w.data);
            end
        end else if (wr_o) begin
            hi_len <= hi_len + 1;
            check("wr_stable", 64'(now_w), 64'(cur_w));
        end else if (wr_d && rst_ni) begin
            check("wr_hold_len", 64'(hi_len), 64'(WR_HOLD));
        end
        wr_d <= wr_o;

        if (done_o) begin
            if (exp_done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got error=%0d expected no done", error_o);
            end else begin
                ed = exp_done_q.pop_front();
                check("done_error", 64'(error_o), 64'(ed.err));
                check("done_rx", rx_data_o, ed.rx);
                $display("done error=%0d rx=0x%016h", error_o, rx_data_o);
            end
        end
    end

    task automatic push_writes(input int n, input logic [63:0] tx, input logic [31:0] ctrl);
        for (int i = 0; i < n; i++)
            exp_wr_q.push_back({1'b1, AW'(i), {24'b0, tx[8*i +: 8]}});
        exp_wr_q.push_back({1'b0, AW'(0), ctrl});
    endtask

    task automatic pulse_start(input int n, input logic [63:0] tx);
        @(posedge clk_i); #1;
        start_i   = 1'b1;
        n_bytes_i = (AW+1)'(n);
        tx_data_i = tx;
        @(posedge clk_i); #1;
        start_i   = 1'b0;
    endtask

    task automatic run_txn(input string tag, input int n, input logic [63:0] tx,
                           input logic [63:0] spi_bytes, input logic [31:0] ctrl,
                           input bit exp_err, input bit stuck_send,
                           input logic [63:0] exp_rx, input bit poke_busy);
        int lat;
        bit seen;
        for (int i = 0; i < N; i++) spi_rx[i] = spi_bytes[8*i +: 8];
        stuck = stuck_send;
        if (n >= 1 && n <= N) begin
            push_writes(n, tx, ctrl);
            exp_wr_q.push_back({1'b0, AW'(0), 32'h0});
        end
        exp_done_q.push_back({exp_err, exp_rx});
        pulse_start(n, tx);
        if (poke_busy) begin
            repeat (30) @(posedge clk_i);
            #1;
            check({tag, "_busy"}, 64'(busy_o), 64'd1);
            start_i   = 1'b1;
            n_bytes_i = '0;
            @(posedge clk_i); #1;
            start_i   = 1'b0;
        end
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 3000) begin
            @(negedge clk_i);
            lat++;
            if (done_o) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (n < 1 || n > N) check({tag, "_latency"}, 64'(lat), 64'd2);
    endtask

    initial begin
        bit found;
        // Reset state
        #22;
        check("reset_wr", 64'(wr_o), 64'd0);
        check("reset_outs", {reg_sel_o, 28'(addr_o), data_o, busy_o, done_o, error_o}, 64'd0);
        check("reset_rx", rx_data_o, 64'd0);
        @(negedge clk_i); #2;
        rst_ni = 1'b1;

        run_txn("n2", 2, 64'h3CA5, 64'h2211, 32'h13, 1'b0, 1'b0, 64'h2211, 1'b0);
        check("n2_rx16", 64'(rx_data_o[15:0]), 64'h2211);
        // Back-to-back start in the cycle after done_o
        run_txn("n8", 8, 64'h0807060504030201, 64'h8786858483828180, 32'h73,
                1'b0, 1'b0, 64'h8786858483828180, 1'b0);
        run_txn("n0", 0, 64'h0, 64'h0, 32'h0, 1'b1, 1'b0, 64'h8786858483828180, 1'b0);
        run_txn("n9", 9, 64'hFF, 64'h0, 32'h0, 1'b1, 1'b0, 64'h8786858483828180, 1'b0);
        run_txn("timeout", 1, 64'h5A, 64'h99, 32'h03, 1'b1, 1'b1, 64'h8786858483828180, 1'b0);
        run_txn("busy_ign", 3, 64'hCCBBAA, 64'hC3C2C1, 32'h23, 1'b0, 1'b0,
                64'h8786858483C3C2C1, 1'b1);
        repeat (5) @(negedge clk_i);

        // Reset during the control write
        stuck = 1'b0;
        push_writes(2, 64'h6677, 32'h13);
        pulse_start(2, 64'h6677);
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk_i);
            if (wr_o && !reg_sel_o) found = 1'b1;
        end
        check("rst_reach_wr_ctrl", 64'(found), 64'd1);
        repeat (3) @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_mid_wr", 64'(wr_o), 64'd0);
        check("rst_mid_outs", {reg_sel_o, 28'(addr_o), data_o, busy_o, done_o, error_o}, 64'd0);
        check("rst_mid_rx", rx_data_o, 64'd0);
        exp_wr_q.delete();
        exp_done_q.delete();
        repeat (3) @(negedge clk_i);
        #2;
        rst_ni = 1'b1;

        run_txn("after_rst", 2, 64'h0201, 64'h4433, 32'h13, 1'b0, 1'b0, 64'h4433, 1'b0);
        repeat (20) @(negedge clk_i);
        check("wr_queue_empty", 64'(exp_wr_q.size()), 64'd0);
        check("done_queue_empty", 64'(exp_done_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
